grasshopper_round_ctrl: RTL and testbench



---
 rtl/kuz_pkg.sv | 62 ++++++
 rtl/grasshopper_round_ctrl_if.sv | 22 ++
 rtl/kuz_r_step.sv | 20 ++
 rtl/grasshopper_round_ctrl.sv | 110 +++++++++++
 tb/tb_grasshopper_round_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/kuz_pkg.sv
// Kuznyechik constants and helpers shared by the round controller and its R-step datapath:
// the pi substitution table, the linear-map coefficients, GF(2^8) multiply and the FSM state type.
package kuz_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_XS,
      ST_LIN,
      ST_FINAL,
      ST_DONE
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'd8;
   localparam logic [3:0] FINAL_KEY  = 4'd9;
   localparam logic [3:0] LAST_RSTEP = 4'd15;

   // pi table, entry 0 in the most significant byte so the rows read in table order.
   localparam logic [2047:0] PI_TABLE = {
      128'hfceedd11cf6e3116fbc4fada23c5044d,
      128'he977f0db932e99ba1736f1bb14cd5fc1,
      128'hf918655ae25cef21811c3c428b018e4f,
      128'h058402aee36a8fa0060bed987fd4d31f,
      128'heb342c51eac848abf22a68a2fd3acecc,
      128'hb5700e56080c7612bf7213479cb75d87,
      128'h15a19629107b9ac7f391786f9d9eb2b1,
      128'h3275193dff358a7e6d54c680c3bd0d57,
      128'hdff524a93ea843c9d779d6f67c22b903,
      128'he00fecde7a94b0bcdce828504e330a4a,
      128'ha79760731e0062441ab83882649f2641,
      128'had454692275e552f8ca3a57d69d5953b,
      128'h0758b34086ac1df730376be488d9e789,
      128'he11b83494c3ff8fe8d53aa90cad88561,
      128'h207167a42d2b095bcb9b25d0bee56c52,
      128'h59a674d2e6f4b4c0d166afc2394b63b6
   };

   // Coefficient applied to byte a_i of the state, index 0 = a0.
   localparam logic [7:0] L_COEF [16] = '{
      8'h01, 8'h94, 8'h20, 8'h85, 8'h10, 8'hc2, 8'hc0, 8'h01,
      8'hfb, 8'h01, 8'hc0, 8'hc2, 8'h10, 8'h85, 8'h20, 8'h94
   };

   function automatic logic [7:0] sbox_byte(input logic [7:0] x);
      int idx;
      idx = (255 - int'(x)) * 8;
      return PI_TABLE[idx +: 8];
   endfunction

   // Shift-and-add multiply, reducing by x^8+x^7+x^6+x+1 whenever x^8 appears.
   function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'hc3) : (x << 1);
      end
      return p;
   endfunction

endpackage

// File: rtl/grasshopper_round_ctrl_if.sv
// Block-level bus of the round controller: plaintext in, ciphertext out, and the round-key fetch.
interface grasshopper_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_i;
   logic [3:0]   key_idx;
   logic [127:0] key_i;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_o;
   logic         busy;

   modport master (
      output in_valid, data_i, key_i, out_ready,
      input  in_ready, key_idx, out_valid, data_o, busy
   );

   modport slave (
      input  in_valid, data_i, key_i, out_ready,
      output in_ready, key_idx, out_valid, data_o, busy
   );
endinterface

// File: rtl/kuz_r_step.sv
// One R-step of the Kuznyechik linear map: the weighted byte sum lands in a15 while the
// remaining bytes shift down one position.
module kuz_r_step
   import kuz_pkg::*;
(
   input  logic [127:0] a_i,
   output logic [127:0] r_o
);

   logic [7:0] l_sum;

   always_comb begin
      l_sum = '0;
      for (int i = 0; i < 16; i++) begin
         l_sum = l_sum ^ gf_mul8(L_COEF[i], a_i[i*8 +: 8]);
      end
      r_o = {l_sum, a_i[127:8]};
   end

endmodule

// File: rtl/grasshopper_round_ctrl.sv
// Iterative Kuznyechik encryptor: nine X-S-L rounds and a closing X over one state register,
// with L done as sixteen serial R-steps through a single shared kuz_r_step.
module grasshopper_round_ctrl
   import kuz_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   grasshopper_round_ctrl_if.slave bus
);

   state_t       state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [3:0]   round_q, round_d;
   logic [3:0]   rcnt_q, rcnt_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;
   logic [127:0] r_out;

   function automatic logic [127:0] sub_bytes(input logic [127:0] x);
      logic [127:0] s;
      for (int i = 0; i < 16; i++) s[i*8 +: 8] = sbox_byte(x[i*8 +: 8]);
      return s;
   endfunction

   kuz_r_step u_r_step (
      .a_i (st_q),
      .r_o (r_out)
   );

   // Key index is decoded straight from state so the key store can answer in the same cycle.
   always_comb begin
      bus.key_idx = '0;
      if (state_q == ST_XS)         bus.key_idx = round_q;
      else if (state_q == ST_FINAL) bus.key_idx = FINAL_KEY;
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves it unassigned (no latch).
      state_d = state_q;
      st_d    = st_q;
      round_d = round_q;
      rcnt_d  = rcnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               st_d    = bus.data_i;
               round_d = '0;
               state_d = ST_XS;
            end
         end
         ST_XS: begin
            st_d    = sub_bytes(st_q ^ bus.key_i);
            rcnt_d  = '0;
            state_d = ST_LIN;
         end
         ST_LIN: begin
            st_d   = r_out;
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == LAST_RSTEP) begin
               if (round_q == LAST_ROUND) begin
                  state_d = ST_FINAL;
               end else begin
                  round_d = round_q + 4'd1;
                  state_d = ST_XS;
               end
            end
         end
         ST_FINAL: begin
            st_d    = st_q ^ bus.key_i;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Handshake flags follow the next state so they are valid right after the edge.
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // NOTE: registers update with <= only, and the synchronous rst wins over any transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         st_q        <= '0;
         round_q     <= '0;
         rcnt_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         round_q     <= round_d;
         rcnt_q      <= rcnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.data_o    = st_q;

endmodule

// File: tb/tb_grasshopper_round_ctrl.sv
// Directed bench for grasshopper_round_ctrl: GOST known-answer vector, key sequencing,
// backpressure, mid-block reset and back-to-back blocks, checked through a ciphertext scoreboard.
module tb_grasshopper_round_ctrl;

   localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
   localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
   localparam int LATENCY = 154;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   grasshopper_round_ctrl_if bus ();

   grasshopper_round_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [127:0] rs_in;
   logic [127:0] rs_out;

   kuz_r_step u_rs (
      .a_i (rs_in),
      .r_o (rs_out)
   );

   logic [127:0] keys [16];
   assign bus.key_i = keys[bus.key_idx];

   int           n_chk = 0;
   int           n_err = 0;
   logic [127:0] sb_q [$];
   logic [3:0]   key_log [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one block for a single edge; the DUT must be idle. Expected ciphertext goes to the scoreboard.
   task automatic send(input string tag, input logic [127:0] d, input logic [127:0] exp_ct);
      check({tag, "_ready_before"}, bus.in_ready, 1'b1);
      bus.data_i   = d;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      sb_q.push_back(exp_ct);
      check({tag, "_busy_after"}, bus.busy, 1'b1);
   endtask

   task automatic wait_out(input string tag, input bit log_keys);
      int n;
      n = 0;
      key_log.delete();
      while (bus.out_valid !== 1'b1 && n < 400) begin
         if (log_keys) key_log.push_back(bus.key_idx);
         tick();
         n++;
      end
      check({tag, "_latency"}, n, LATENCY);
   endtask

   task automatic expect_out(input string tag);
      logic [127:0] exp_ct;
      check({tag, "_pending"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         exp_ct = sb_q.pop_front();
         check(tag, bus.data_o, exp_ct);
      end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] held;
      logic [3:0]   exp_k;
      int           unstable;
      int           bad;
      int           nz;

      for (int i = 0; i < 16; i++) keys[i] = '0;
      keys[0] = 128'h8899aabbccddeeff0011223344556677;
      keys[1] = 128'hfedcba98765432100123456789abcdef;
      keys[2] = 128'hdb31485315694343228d6aef8cc78c44;
      keys[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
      keys[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
      keys[5] = 128'hbd079435165c6432b532e82834da581b;
      keys[6] = 128'h51e640757e8745de705727265a0098b1;
      keys[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
      keys[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
      keys[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.data_i    = '0;
      rs_in         = '0;
      repeat (3) tick();

      check("rst_in_ready",  bus.in_ready,  1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy",      bus.busy,      1'b0);
      check("rst_key_idx",   bus.key_idx,   4'd0);
      check("rst_data_o",    bus.data_o,    128'h0);
      rst = 1'b0;
      tick();
      check("idle_in_ready", bus.in_ready, 1'b1);

      rs_in = 128'h00000000000000000000000000000100;
      #1;
      check("r_step_unit", rs_out, 128'h94000000000000000000000000000001);

      // GOST vector with key-index logging from the cycle after accept through FINAL.
      send("gost", PT, CT);
      check("gost_in_ready_busy", bus.in_ready, 1'b0);
      wait_out("gost", 1'b1);
      check("key_log_len", key_log.size(), LATENCY);
      bad = 0;
      nz  = 0;
      foreach (key_log[k]) begin
         if (k == LATENCY - 1)              exp_k = 4'd9;
         else if (k % 17 == 0 && k <= 136) exp_k = 4'(k / 17);
         else                               exp_k = 4'd0;
         if (key_log[k] !== exp_k) bad++;
         if (key_log[k] != 4'd0) nz++;
      end
      check("key_seq_mismatches", bad, 0);
      check("key_nonzero_count", nz, 9);

      // Stall the consumer for 20 cycles and poke in_valid in the middle.
      held     = bus.data_o;
      unstable = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin
            bus.in_valid = 1'b1;
            bus.data_i   = ~PT;
         end
         if (c == 7) bus.in_valid = 1'b0;
         if (bus.out_valid !== 1'b1 || bus.data_o !== held || bus.in_ready !== 1'b0) unstable++;
         tick();
      end
      check("stall_stable", unstable, 0);
      check("stall_out_valid", bus.out_valid, 1'b1);
      expect_out("gost_ct");
      handshake();
      check("hs_in_ready",  bus.in_ready,  1'b1);
      check("hs_out_valid", bus.out_valid, 1'b0);
      check("hs_busy",      bus.busy,      1'b0);

      // Abort during LIN of round 4 (cycles 69..84 after accept).
      send("abort", PT, CT);
      repeat (75) tick();
      check("abort_busy_before", bus.busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(sb_q.pop_back());
      check("abort_in_ready",  bus.in_ready,  1'b1);
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_busy",      bus.busy,      1'b0);
      check("abort_data_o",    bus.data_o,    128'h0);
      send("after_rst", PT, CT);
      wait_out("after_rst", 1'b0);
      expect_out("after_rst_ct");
      handshake();

      // Back-to-back: in_valid held high across the first block's output handshake.
      bus.data_i   = PT;
      bus.in_valid = 1'b1;
      tick();
      sb_q.push_back(CT);
      check("b2b0_busy", bus.busy, 1'b1);
      wait_out("b2b0", 1'b0);
      expect_out("b2b0_ct");
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("b2b_ed_in_ready",  bus.in_ready,  1'b1);
      check("b2b_ed_out_valid", bus.out_valid, 1'b0);
      tick();
      sb_q.push_back(CT);
      bus.in_valid = 1'b0;
      check("b2b1_in_ready", bus.in_ready, 1'b0);
      check("b2b1_busy",     bus.busy,     1'b1);
      wait_out("b2b1", 1'b0);
      expect_out("b2b1_ct");
      handshake();
      check("b2b_done_idle", bus.in_ready, 1'b1);
      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
